output_unit_vc: RTL

Parametrised router output port with NUM_VC virtual-channel FIFOs, per-VC credit-based flow control toward the downstream router, and round-robin flit-level arbitration onto one output link. It sits between the crossbar and the inter-router link, replacing the single-buffer output unit. Flit type travels in the top two bits: 00 invalid, 01 head, 10 body, 11 tail.

---
 rtl/output_unit_vc.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/output_unit_vc.sv
`default_nettype none
// ============================================================================
// output_unit_vc : router output port with per-VC FIFOs, per-VC downstream
//                  credits and round-robin flit arbitration onto one link.
// Revision: 1.0
// ============================================================================
module output_unit_vc #(
  parameter  int FLIT_W  = 64,
  parameter  int DEPTH   = 4,
  parameter  int NUM_VC  = 2,
  parameter  int CREDITS = 4,
  localparam int VW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int KW      = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [VW-1:0]        push_vc,
  input  logic [FLIT_W-1:0]    bf_in,
  input  logic                 alloc,
  input  logic [VW-1:0]        alloc_vc,
  input  logic                 credit_in,
  input  logic [VW-1:0]        credit_vc,
  input  logic                 write_req_ack,
  output logic [FLIT_W-1:0]    bf_out,
  output logic [VW-1:0]        write_vc,
  output logic                 write_req,
  output logic [NUM_VC*CW-1:0] em_pl,
  output logic [NUM_VC-1:0]    allocOrnot,
  output logic                 overflow
);

  localparam int         PW        = $clog2(DEPTH);
  localparam logic [1:0] TYPE_INV  = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  logic [FLIT_W-1:0] mem_q  [NUM_VC][DEPTH];
  logic [PW-1:0]     wptr_q [NUM_VC];
  logic [PW-1:0]     wptr_d [NUM_VC];
  logic [PW-1:0]     rptr_q [NUM_VC];
  logic [PW-1:0]     rptr_d [NUM_VC];
  logic [CW-1:0]     free_q [NUM_VC];
  logic [CW-1:0]     free_d [NUM_VC];
  logic [KW-1:0]     cred_q [NUM_VC];
  logic [KW-1:0]     cred_d [NUM_VC];
  logic [VW-1:0]     rr_q, rr_d;
  logic [FLIT_W-1:0] bf_out_q, bf_out_d;
  logic [VW-1:0]     write_vc_q, write_vc_d;
  logic              write_req_q, write_req_d;
  logic [NUM_VC-1:0] busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic              w_ack;
  logic              w_push_ok;
  logic [NUM_VC-1:0] w_wr;
  logic [NUM_VC-1:0] w_pop;
  logic [NUM_VC-1:0] w_inc;
  logic [NUM_VC-1:0] w_elig;
  logic              w_found;
  logic [VW-1:0]     w_sel;
  logic [FLIT_W-1:0] w_head;

  assign w_ack     = write_req_q & write_req_ack;
  assign w_push_ok = push & (bf_in[FLIT_W-1 -: 2] != TYPE_INV);

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_wr[v]   = w_push_ok && (push_vc == VW'(v)) && (free_q[v] != '0);
      w_pop[v]  = w_ack && (write_vc_q == VW'(v));
      w_inc[v]  = credit_in && (credit_vc == VW'(v));
      w_elig[v] = (free_q[v] != CW'(DEPTH)) && (cred_q[v] != '0);
    end
  end

  // Round-robin search starting at rr; the head flit is peeked, popped on ack.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_head  = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % NUM_VC;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_sel   = VW'(idx);
        w_head  = mem_q[idx][rptr_q[idx]];
      end
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    free_d      = free_q;
    cred_d      = cred_q;
    rr_d        = rr_q;
    bf_out_d    = bf_out_q;
    write_vc_d  = write_vc_q;
    write_req_d = write_req_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;

    for (int v = 0; v < NUM_VC; v++) begin
      if (w_wr[v])  wptr_d[v] = wptr_q[v] + PW'(1);
      if (w_pop[v]) rptr_d[v] = rptr_q[v] + PW'(1);
      if (w_wr[v] && !w_pop[v])      free_d[v] = free_q[v] - CW'(1);
      else if (!w_wr[v] && w_pop[v]) free_d[v] = free_q[v] + CW'(1);
      if (w_push_ok && (push_vc == VW'(v)) && (free_q[v] == '0)) ovf_d = 1'b1;

      // A returned credit and a consumed credit on one VC cancel out.
      if (w_inc[v] && !w_pop[v]) begin
        if (cred_q[v] == KW'(CREDITS)) ovf_d = 1'b1;
        else                           cred_d[v] = cred_q[v] + KW'(1);
      end else if (w_pop[v] && !w_inc[v]) begin
        cred_d[v] = cred_q[v] - KW'(1);
      end

      if (w_pop[v] && (bf_out_q[FLIT_W-1 -: 2] == TYPE_TAIL)) busy_d[v] = 1'b0;
      if (alloc && (alloc_vc == VW'(v)))                      busy_d[v] = 1'b1;
    end

    if (w_ack) begin
      write_req_d = 1'b0;
      rr_d        = (write_vc_q == VW'(NUM_VC - 1)) ? '0 : write_vc_q + VW'(1);
    end else if (!write_req_q && w_found) begin
      write_req_d = 1'b1;
      bf_out_d    = w_head;
      write_vc_d  = w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
        free_q[v] <= CW'(DEPTH);
        cred_q[v] <= KW'(CREDITS);
      end
      rr_q        <= '0;
      bf_out_q    <= '0;
      write_vc_q  <= '0;
      write_req_q <= 1'b0;
      busy_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      free_q      <= free_d;
      cred_q      <= cred_d;
      rr_q        <= rr_d;
      bf_out_q    <= bf_out_d;
      write_vc_q  <= write_vc_d;
      write_req_q <= write_req_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_wr[v]) mem_q[v][wptr_q[v]] <= bf_in;
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_empl
    assign em_pl[g*CW +: CW] = free_q[g];
  end

  assign bf_out     = bf_out_q;
  assign write_vc   = write_vc_q;
  assign write_req  = write_req_q;
  assign allocOrnot = busy_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire
